aes_decrypt_controller: RTL and testbench

FSM controller for iterative AES-128 decryption (FIPS-197 inverse cipher), the receive-side counterpart of the encryption controller in the same AES core.
- Drives the shared forward key expander to collect round keys 1..10 into a local buffer.
- Sequences an external combinational inverse-round datapath from round 10 down to round 0.
- Returns the recovered plaintext with a one-cycle completion pulse.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_round_key_buffer.sv | 33 +++
 rtl/aes_decrypt_controller.sv | 140 ++++++++++++++
 tb/tb_aes_decrypt_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES core types and constants
package aes_pkg;

    localparam int AES_NR      = 10;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_RK_NUM  = AES_NR + 1;
    localparam int AES_RK_AW   = 4;

    typedef enum logic [1:0] {
        DEC_IDLE      = 2'd0,
        DEC_LOAD_KEYS = 2'd1,
        DEC_ROUNDS    = 2'd2
    } dec_fsm_e;

endpackage

// File: rtl/aes_round_key_buffer.sv
// rtl/aes_round_key_buffer.sv - round key register file, one sync write, one comb read
module aes_round_key_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH = AES_RK_NUM,
    parameter int W     = AES_BLOCK_W,
    parameter int AW    = AES_RK_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // No reset: every entry is written before it can be read in a decryption.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i <= AW'(DEPTH - 1))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (raddr_i <= AW'(DEPTH - 1)) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/aes_decrypt_controller.sv
// rtl/aes_decrypt_controller.sv - AES-128 inverse cipher sequencer with local round key buffer
module aes_decrypt_controller
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_decryption,
    input  logic [BLOCK_W-1:0] cipher_text,
    input  logic [BLOCK_W-1:0] original_key,
    output logic               start_expansion,
    output logic [3:0]         exp_round,
    output logic [BLOCK_W-1:0] prev_key,
    input  logic               key_valid,
    input  logic [BLOCK_W-1:0] next_key,
    output logic [BLOCK_W-1:0] inv_round_in,
    output logic [BLOCK_W-1:0] inv_round_key,
    output logic               final_round,
    input  logic [BLOCK_W-1:0] inv_round_out,
    output logic               busy,
    output logic [BLOCK_W-1:0] plain_text,
    output logic               finished_decryption
);

    localparam int               RK_AW   = AES_RK_AW;
    localparam logic [RK_AW-1:0] LAST_RK = RK_AW'(NR);

    dec_fsm_e           state_q;
    logic [RK_AW-1:0]   key_idx_q;
    logic [RK_AW-1:0]   round_q;
    logic [BLOCK_W-1:0] cipher_q;
    logic [BLOCK_W-1:0] text_q;
    logic [BLOCK_W-1:0] plain_text_q;
    logic               finished_q;

    logic               buf_we;
    logic [RK_AW-1:0]   buf_waddr;
    logic [RK_AW-1:0]   buf_raddr;
    logic [BLOCK_W-1:0] buf_wdata;
    logic [BLOCK_W-1:0] buf_rdata;

    // The single read port serves the expander while loading and the datapath while decrypting.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = '0;
        buf_raddr = '0;
        case (state_q)
            DEC_IDLE: begin
                buf_we    = start_decryption;
                buf_wdata = original_key;
            end
            DEC_LOAD_KEYS: begin
                buf_we    = key_valid;
                buf_waddr = key_idx_q;
                buf_wdata = next_key;
                buf_raddr = key_idx_q - RK_AW'(1);
            end
            DEC_ROUNDS: begin
                buf_raddr = round_q;
            end
            default: begin
                buf_we = 1'b0;
            end
        endcase
    end

    aes_round_key_buffer #(
        .DEPTH (NR + 1),
        .W     (BLOCK_W),
        .AW    (RK_AW)
    ) u_key_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DEC_IDLE;
            key_idx_q    <= '0;
            round_q      <= '0;
            text_q       <= '0;
            plain_text_q <= '0;
            finished_q   <= 1'b0;
        end else begin
            plain_text_q <= '0;
            finished_q   <= 1'b0;
            case (state_q)
                DEC_IDLE: begin
                    if (start_decryption) begin
                        cipher_q  <= cipher_text;
                        key_idx_q <= RK_AW'(1);
                        state_q   <= DEC_LOAD_KEYS;
                    end
                end
                DEC_LOAD_KEYS: begin
                    if (key_valid) begin
                        key_idx_q <= key_idx_q + RK_AW'(1);
                        // Last key folds the initial AddRoundKey into the load cycle.
                        if (key_idx_q == LAST_RK) begin
                            text_q  <= cipher_q ^ next_key;
                            round_q <= LAST_RK - RK_AW'(1);
                            state_q <= DEC_ROUNDS;
                        end
                    end
                end
                DEC_ROUNDS: begin
                    text_q <= inv_round_out;
                    if (round_q == '0) begin
                        plain_text_q <= inv_round_out;
                        finished_q   <= 1'b1;
                        state_q      <= DEC_IDLE;
                    end else begin
                        round_q <= round_q - RK_AW'(1);
                    end
                end
                default: begin
                    state_q <= DEC_IDLE;
                end
            endcase
        end
    end

    assign start_expansion     = (state_q == DEC_IDLE) && start_decryption;
    assign exp_round           = (state_q == DEC_LOAD_KEYS) ? key_idx_q : 4'd0;
    assign prev_key            = (state_q == DEC_LOAD_KEYS) ? buf_rdata : '0;
    assign inv_round_in        = (state_q == DEC_ROUNDS) ? text_q : '0;
    assign inv_round_key       = (state_q == DEC_ROUNDS) ? buf_rdata : '0;
    assign final_round         = (state_q == DEC_ROUNDS) && (round_q == '0);
    assign busy                = (state_q != DEC_IDLE);
    assign plain_text          = plain_text_q;
    assign finished_decryption = finished_q;

endmodule

// File: tb/tb_aes_decrypt_controller.sv
// tb/tb_aes_decrypt_controller.sv - self-checking bench with AES key expander, inverse round and cycle model
module tb_aes_decrypt_controller;

    localparam int M_NORM    = 0;
    localparam int M_STALL   = 1;
    localparam int M_REPULSE = 2;
    localparam int M_RESET   = 3;
    localparam int M_RAND    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start_decryption;
    logic [127:0] cipher_text;
    logic [127:0] original_key;
    logic         start_expansion;
    logic [3:0]   exp_round;
    logic [127:0] prev_key;
    logic         key_valid;
    logic [127:0] next_key;
    logic [127:0] inv_round_in;
    logic [127:0] inv_round_key;
    logic         final_round;
    logic [127:0] inv_round_out;
    logic         busy;
    logic [127:0] plain_text;
    logic         finished_decryption;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    aes_decrypt_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .start_decryption    (start_decryption),
        .cipher_text         (cipher_text),
        .original_key        (original_key),
        .start_expansion     (start_expansion),
        .exp_round           (exp_round),
        .prev_key            (prev_key),
        .key_valid           (key_valid),
        .next_key            (next_key),
        .inv_round_in        (inv_round_in),
        .inv_round_key       (inv_round_key),
        .final_round         (final_round),
        .inv_round_out       (inv_round_out),
        .busy                (busy),
        .plain_text          (plain_text),
        .finished_decryption (finished_decryption)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] prev, input int rnd);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = (rnd == 0) ? 8'h00 : 8'h01;
        for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
        {w0, w1, w2, w3} = prev;
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [10:0][127:0] expand_all(input logic [127:0] k);
        logic [10:0][127:0] rk;
        rk[0] = k;
        for (int i = 1; i <= 10; i++) rk[i] = key_step(rk[i-1], i);
        return rk;
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [7:0]   a [16];
        logic [127:0] t, o;
        logic [7:0]   c0, c1, c2, c3;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(r+4*c) -: 8] = isbox[a[r + 4*((c - r + 4) % 4)]];
        t = t ^ rk;
        if (last) return t;
        for (int c = 0; c < 4; c++) begin
            c0 = t[127-8*(4*c)   -: 8];
            c1 = t[127-8*(4*c+1) -: 8];
            c2 = t[127-8*(4*c+2) -: 8];
            c3 = t[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
            o[127-8*(4*c+1) -: 8] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
            o[127-8*(4*c+2) -: 8] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
            o[127-8*(4*c+3) -: 8] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] c);
        logic [10:0][127:0] rk;
        logic [127:0]       s;
        rk = expand_all(k);
        s  = c ^ rk[10];
        for (int r = 9; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
        return s;
    endfunction

    // Environment: shared forward key expander and combinational inverse-round datapath.
    always_comb begin
        next_key      = key_step(prev_key, int'(exp_round));
        inv_round_out = inv_round(inv_round_in, inv_round_key, final_round);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Cycle model: phase, number of round keys collected, number of rounds done.
    int                 m_phase = 0;
    int                 m_loaded = 0;
    int                 m_rdone = 0;
    logic [10:0][127:0] m_rk;
    logic [127:0]       m_ct;
    logic [127:0]       m_text = '0;
    logic [127:0]       m_pt = '0;
    logic               m_fin = 1'b0;
    bit                 cmp_en = 1'b0;

    always @(posedge clk) begin
        m_fin <= 1'b0;
        m_pt  <= '0;
        if (reset) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (start_decryption) begin
                    m_rk     <= expand_all(original_key);
                    m_ct     <= cipher_text;
                    m_loaded <= 0;
                    m_phase  <= 1;
                end
                1: if (key_valid) begin
                    m_loaded <= m_loaded + 1;
                    if (m_loaded == 9) begin
                        m_text  <= m_ct ^ m_rk[10];
                        m_rdone <= 0;
                        m_phase <= 2;
                    end
                end
                default: begin
                    m_text <= inv_round(m_text, m_rk[9-m_rdone], m_rdone == 9);
                    if (m_rdone == 9) begin
                        m_fin   <= 1'b1;
                        m_pt    <= inv_round(m_text, m_rk[0], 1'b1);
                        m_phase <= 0;
                    end else begin
                        m_rdone <= m_rdone + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 128'(busy), 128'(m_phase != 0));
            chk("start_expansion", 128'(start_expansion), 128'(m_phase == 0 && start_decryption));
            chk("exp_round", 128'(exp_round), (m_phase == 1) ? 128'(m_loaded + 1) : 128'(0));
            chk("prev_key", prev_key, (m_phase == 1) ? m_rk[m_loaded] : 128'(0));
            chk("inv_round_in", inv_round_in, (m_phase == 2) ? m_text : 128'(0));
            chk("inv_round_key", inv_round_key, (m_phase == 2) ? m_rk[9-m_rdone] : 128'(0));
            chk("final_round", 128'(final_round), 128'(m_phase == 2 && m_rdone == 9));
            chk("finished", 128'(finished_decryption), 128'(m_fin));
            chk("plain_text", plain_text, m_pt);
        end
    end

    task automatic run_op(input logic [127:0] k, input logic [127:0] c, input int mode,
                          input logic [127:0] exp_pt, input int exp_lat, input string name);
        int cyc;
        int fin_cnt;
        original_key     = k;
        cipher_text      = c;
        start_decryption = 1'b1;
        key_valid        = 1'b1;
        @(posedge clk); #1;
        start_decryption = 1'b0;
        original_key     = {$urandom, $urandom, $urandom, $urandom};
        cipher_text      = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        if (mode == M_RESET) begin
            while (cyc < 14) begin
                @(posedge clk); #1;
                cyc++;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk({name, "_busy_after_reset"}, 128'(busy), 128'(0));
            chk({name, "_pt_after_reset"}, plain_text, 128'(0));
            fin_cnt = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (finished_decryption) fin_cnt++;
            end
            chk({name, "_no_finish"}, 128'(fin_cnt), 128'(0));
            return;
        end
        while (!finished_decryption && cyc < 200) begin
            if (mode == M_STALL)     key_valid = !(cyc == 2 || cyc == 5 || cyc == 8);
            else if (mode == M_RAND) key_valid = ($urandom_range(3) != 0);
            else                     key_valid = 1'b1;
            start_decryption = (mode == M_REPULSE && (cyc == 5 || cyc == 15)) ||
                               (mode == M_RAND && $urandom_range(7) == 0);
            cipher_text = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
        end
        start_decryption = 1'b0;
        key_valid        = 1'b1;
        if (exp_lat != 0) chk({name, "_latency"}, 128'(cyc), 128'(exp_lat));
        chk({name, "_finished"}, 128'(finished_decryption), 128'(1));
        chk({name, "_plaintext"}, plain_text, exp_pt);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]         inv;
        logic [10:0][127:0] rk;
        logic [127:0]       rk_key, rk_ct;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

        rk = expand_all(C1_KEY);
        chk("model_rk10", rk[10], C1_RK10);
        chk("model_dec_c1", aes_dec(C1_KEY, C1_CT), C1_PT);
        chk("model_dec_b", aes_dec(B_KEY, B_CT), B_PT);

        reset            = 1'b1;
        start_decryption = 1'b0;
        key_valid        = 1'b0;
        cipher_text      = '0;
        original_key     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_finished", 128'(finished_decryption), 128'(0));
        chk("reset_plain_text", plain_text, 128'(0));
        chk("reset_exp_round", 128'(exp_round), 128'(0));
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_op(C1_KEY, C1_CT, M_NORM,    C1_PT, 21, "c1");
        run_op(C1_KEY, C1_CT, M_STALL,   C1_PT, 24, "c1_stall");
        run_op(B_KEY,  B_CT,  M_NORM,    B_PT,  21, "b_back2back");
        run_op(B_KEY,  B_CT,  M_REPULSE, B_PT,  21, "b_repulse");
        run_op(C1_KEY, C1_CT, M_RESET,   C1_PT, 0,  "c1_reset");
        run_op(C1_KEY, C1_CT, M_NORM,    C1_PT, 21, "c1_after_reset");

        for (int n = 0; n < 12; n++) begin
            rk_key = {$urandom, $urandom, $urandom, $urandom};
            rk_ct  = {$urandom, $urandom, $urandom, $urandom};
            run_op(rk_key, rk_ct, M_RAND, aes_dec(rk_key, rk_ct), 0, "random");
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
